// File: rtl/md_pkg.sv
// Shared op encodings and cycle-count defaults for the multiply/divide unit.
// MD_UNIT_MACC_EN enables the multiply-accumulate encodings in md_unit.
package md_pkg;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W           = 8;

  typedef enum logic [3:0] {
    MD_MULT  = 4'd0,
    MD_MULTU = 4'd1,
    MD_DIV   = 4'd2,
    MD_DIVU  = 4'd3,
    MD_MTHI  = 4'd4,
    MD_MTLO  = 4'd5,
    MD_MADD  = 4'd6,
    MD_MADDU = 4'd7,
    MD_MSUB  = 4'd8,
    MD_MSUBU = 4'd9
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_cnt.sv
// Load/decrement down-counter for the multi-cycle busy window.
// done flags the last busy cycle (count of one).
module md_cnt
  import md_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers and a fixed-latency busy window.
// Define MD_UNIT_MACC_EN to enable MADD/MADDU/MSUB/MSUBU.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        flush,
  input  logic        md_use_D,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] thi_q, thi_d;
  logic [31:0] tlo_q, tlo_d;
  logic        twr_q, twr_d;

  logic             start_eff;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             cnt_done;

  logic [63:0] prod_u;
  logic [63:0] prod_s;
  logic [31:0] a_mag, b_mag;
  logic [31:0] sq_mag, sr_mag;
  logic [31:0] sq, sr;
  logic [31:0] uq, ur;

  logic        go;
  logic        wr;
  logic [63:0] res;
  logic [CNT_W-1:0] cyc;
`ifdef MD_UNIT_MACC_EN
  logic [63:0] acc;
`endif

  assign start_eff = start & ~flush;

  assign prod_u = {32'd0, A} * {32'd0, B};
  assign prod_s = $signed({{32{A[31]}}, A})
                * $signed({{32{B[31]}}, B});

  // Signed divide via magnitudes avoids the MIN/-1 overflow corner.
  assign a_mag  = A[31] ? (~A + 32'd1) : A;
  assign b_mag  = B[31] ? (~B + 32'd1) : B;
  assign sq_mag = a_mag / b_mag;
  assign sr_mag = a_mag % b_mag;
  assign sq     = (A[31] ^ B[31]) ? (~sq_mag + 32'd1) : sq_mag;
  assign sr     = A[31] ? (~sr_mag + 32'd1) : sr_mag;
  assign uq     = A / B;
  assign ur     = A % B;

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    thi_d    = thi_q;
    tlo_d    = tlo_q;
    twr_d    = twr_q;
    load     = 1'b0;
    load_val = '0;
    go       = 1'b0;
    wr       = 1'b1;
    res      = '0;
    cyc      = '0;
`ifdef MD_UNIT_MACC_EN
    acc      = {hi_q, lo_q};
`endif
    case (state_q)
      S_IDLE: begin
        if (start_eff) begin
          case (md_op)
            MD_MULT: begin
              go  = 1'b1;
              res = prod_s;
              cyc = CNT_W'(MULT_CYCLES);
            end
            MD_MULTU: begin
              go  = 1'b1;
              res = prod_u;
              cyc = CNT_W'(MULT_CYCLES);
            end
            MD_DIV: begin
              go  = 1'b1;
              wr  = (B != 32'd0);
              res = {sr, sq};
              cyc = CNT_W'(DIV_CYCLES);
            end
            MD_DIVU: begin
              go  = 1'b1;
              wr  = (B != 32'd0);
              res = {ur, uq};
              cyc = CNT_W'(DIV_CYCLES);
            end
            MD_MTHI: hi_d = A;
            MD_MTLO: lo_d = A;
`ifdef MD_UNIT_MACC_EN
            MD_MADD: begin
              go  = 1'b1;
              res = acc + prod_s;
              cyc = CNT_W'(MULT_CYCLES);
            end
            MD_MADDU: begin
              go  = 1'b1;
              res = acc + prod_u;
              cyc = CNT_W'(MULT_CYCLES);
            end
            MD_MSUB: begin
              go  = 1'b1;
              res = acc - prod_s;
              cyc = CNT_W'(MULT_CYCLES);
            end
            MD_MSUBU: begin
              go  = 1'b1;
              res = acc - prod_u;
              cyc = CNT_W'(MULT_CYCLES);
            end
`endif
            default: ;
          endcase
        end
        if (go) begin
          state_d  = S_BUSY;
          load     = 1'b1;
          load_val = cyc;
          thi_d    = res[63:32];
          tlo_d    = res[31:0];
          twr_d    = wr;
        end
      end
      S_BUSY: begin
        if (cnt_done) begin
          state_d = S_IDLE;
          if (twr_q) begin
            hi_d = thi_q;
            lo_d = tlo_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      thi_q   <= '0;
      tlo_q   <= '0;
      twr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      thi_q   <= thi_d;
      tlo_q   <= tlo_d;
      twr_q   <= twr_d;
    end
  end

  md_cnt u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .done     (cnt_done)
  );

  assign busy     = (state_q == S_BUSY);
  assign stall_md = md_use_D & (start_eff | busy);
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Randomized self-checking bench for md_unit against a behavioural HI/LO model.
// Honours MD_UNIT_MACC_EN for the multiply-accumulate expectations.
module tb_md_unit;
  import md_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  md_op = 4'd0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        flush = 1'b0;
  logic        md_use_D = 1'b0;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .A        (A),
    .B        (B),
    .flush    (flush),
    .md_use_D (md_use_D),
    .busy     (busy),
    .stall_md (stall_md),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  // Architectural effect of one op; returns its busy length.
  function automatic int model(input logic [3:0] op,
                               input logic [31:0] a,
                               input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r = {m_hi, m_lo};
    model = 0;
    case (op)
      MD_MULT: begin r = sa * sb; model = MC; end
      MD_MULTU: begin r = ua * ub; model = MC; end
      MD_DIV: begin
        if (b != 0) r = {32'(sa % sb), 32'(sa / sb)};
        model = DC;
      end
      MD_DIVU: begin
        if (b != 0) r = {a % b, a / b};
        model = DC;
      end
      MD_MTHI: r[63:32] = a;
      MD_MTLO: r[31:0] = a;
`ifdef MD_UNIT_MACC_EN
      MD_MADD: begin r = r + 64'(sa * sb); model = MC; end
      MD_MADDU: begin r = r + 64'(ua * ub); model = MC; end
      MD_MSUB: begin r = r - 64'(sa * sb); model = MC; end
      MD_MSUBU: begin r = r - 64'(ua * ub); model = MC; end
`endif
      default: ;
    endcase
    m_hi = r[63:32];
    m_lo = r[31:0];
  endfunction

  task automatic do_op(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic fl,
                       input logic use_d, input string tag);
    int exp_n, n;
    logic stall_bad;
    @(negedge clk);
    start = 1'b1; md_op = op; A = a; B = b;
    flush = fl; md_use_D = use_d;
    #1;
    n_checks++;
    if (stall_md !== (use_d & ~fl)) begin
      n_fail++;
      $display("FAIL %s start_stall: got %b want %b", tag, stall_md, use_d & ~fl);
    end
    exp_n = fl ? 0 : model(op, a, b);
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    n = 0; stall_bad = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (stall_md !== use_d) stall_bad = 1'b1;
    end
    n_checks++;
    if (n != exp_n) begin
      n_fail++;
      $display("FAIL %s busy_cycles: got %0d want %0d", tag, n, exp_n);
    end
    n_checks++;
    if (hi !== m_hi) begin
      n_fail++;
      $display("FAIL %s hi: got %h want %h", tag, hi, m_hi);
    end
    n_checks++;
    if (lo !== m_lo) begin
      n_fail++;
      $display("FAIL %s lo: got %h want %h", tag, lo, m_lo);
    end
    n_checks++;
    if (stall_bad || stall_md !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy_stall: bad=%b end=%b want 0/0", tag, stall_bad, stall_md);
    end
    md_use_D = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || stall_md !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: busy=%b hi=%h lo=%h stall=%b want 0", busy, hi, lo, stall_md);
    end
    reset = 1'b1;
  endtask

  task automatic test_mult();
    do_op(MD_MULT, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0, "mult");
    n_checks++;
    if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFA) begin
      n_fail++;
      $display("FAIL mult_const: got %h%h want ffffffff fffffffa", hi, lo);
    end
    do_op(MD_MULTU, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0, "multu");
    n_checks++;
    if ({hi, lo} !== 64'h00000002_FFFFFFFA) begin
      n_fail++;
      $display("FAIL multu_const: got %h%h want 00000002 fffffffa", hi, lo);
    end
  endtask

  task automatic test_div();
    do_op(MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, "div");
    n_checks++;
    if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
      n_fail++;
      $display("FAIL div_const: got hi=%h lo=%h want ffffffff fffffffd", hi, lo);
    end
    do_op(MD_DIVU, 32'd7, 32'd0, 1'b0, 1'b0, "divu_zero");
    n_checks++;
    if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
      n_fail++;
      $display("FAIL divu_zero_const: got hi=%h lo=%h want unchanged", hi, lo);
    end
    do_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, "div_min");
  endtask

  task automatic test_flush_mt();
    do_op(MD_MULT, 32'd9, 32'd9, 1'b1, 1'b1, "flush_start");
    do_op(MD_MTLO, 32'h1234, 32'd0, 1'b0, 1'b0, "mtlo");
    n_checks++;
    if (lo !== 32'h1234) begin
      n_fail++;
      $display("FAIL mtlo_const: got %h want 00001234", lo);
    end
    do_op(MD_MTHI, 32'hCAFE0001, 32'd0, 1'b0, 1'b1, "mthi");
  endtask

  // flush and a stray start during BUSY must not disturb the op in flight.
  task automatic test_busy_ignore();
    int n;
    int exp_n;
    @(negedge clk);
    start = 1'b1; md_op = MD_MULTU; A = 32'h10001; B = 32'h30003;
    exp_n = model(MD_MULTU, 32'h10001, 32'h30003);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; start = 1'b1; md_op = MD_MTLO; A = 32'hDEAD;
    @(posedge clk);
    #1 start = 1'b0;
    n = 2;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    n_checks++;
    if (n != exp_n || hi !== m_hi || lo !== m_lo) begin
      n_fail++;
      $display("FAIL busy_ignore: n=%0d hi=%h lo=%h want %0d %h %h", n, hi, lo, exp_n, m_hi, m_lo);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_op(MD_MTLO, 32'h55, 32'd0, 1'b0, 1'b0, "pre_rst");
    @(negedge clk);
    start = 1'b1; md_op = MD_MULT; A = 32'd100; B = 32'd100;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    for (int i = 0; i < 64 && n < 3; i++) begin
      @(negedge clk);
      if (busy) n++;
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b hi=%h lo=%h want 0", busy, hi, lo);
    end
    @(negedge clk);
    reset = 1'b1;
    m_hi = '0; m_lo = '0;
    repeat (6) @(negedge clk);
    n_checks++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_discard: hi=%h lo=%h want 0", hi, lo);
    end
    do_op(MD_MULT, 32'd2, 32'd3, 1'b0, 1'b0, "post_rst");
    n_checks++;
    if (lo !== 32'd6) begin
      n_fail++;
      $display("FAIL post_rst_const: got %h want 6", lo);
    end
  endtask

  task automatic test_macc();
    do_op(MD_MTHI, 32'd0, 32'd0, 1'b0, 1'b0, "macc_hi");
    do_op(MD_MTLO, 32'd10, 32'd0, 1'b0, 1'b0, "macc_lo");
    do_op(MD_MADD, 32'd2, 32'd3, 1'b0, 1'b1, "madd");
    n_checks++;
`ifdef MD_UNIT_MACC_EN
    if (lo !== 32'd16) begin
      n_fail++;
      $display("FAIL madd_const: got %h want 16", lo);
    end
`else
    if (lo !== 32'd10) begin
      n_fail++;
      $display("FAIL madd_noop_const: got %h want 10", lo);
    end
`endif
    do_op(MD_MSUBU, 32'hFFFFFFFF, 32'd7, 1'b0, 1'b0, "msubu");
  endtask

  task automatic test_back_to_back();
    logic [3:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 11));
      case ($urandom_range(0, 3))
        0: a = 32'h80000000;
        1: a = 32'hFFFFFFFF;
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = {28'd0, 4'($urandom)};
      do_op(op, a, b, ($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 1)), "rand");
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_flush_mt();
    test_busy_ignore();
    test_reset_mid();
    test_macc();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
